// File: rtl/block_xfer_sequencer.sv
// Block data transfer sequencer (LDM/STM, IA/IB/DA/DB).
// Walks the latched register mask lowest index first, issuing one memory
// beat per set bit, then does optional base writeback and pulses done.
//
// Handshake: mem_req is a valid; a beat transfers in any cycle where
// mem_req & mem_ready. While mem_ready is low, mem_req, mem_addr, reg_idx
// and mem_we are held stable and nothing advances. There is no timeout.
module block_xfer_sequencer #(
    parameter int NREGS  = 16,
    parameter int AW     = 32,
    parameter int WBYTES = 4,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NREGS-1:0] reg_list,
    input  logic [AW-1:0]    base_addr,
    input  logic [RW-1:0]    base_reg,
    input  logic             p_bit,
    input  logic             u_bit,
    input  logic             l_bit,
    input  logic             w_bit,
    input  logic             mem_ready,
    output logic             busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [RW-1:0]    reg_idx,
    output logic             reg_we,
    output logic             wb_we,
    output logic [AW-1:0]    wb_data,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [AW-1:0]    STEP     = AW'(WBYTES);
    localparam logic [NREGS-1:0] MASK_ONE = NREGS'(1);

    state_t             state_q, state_d;
    logic [NREGS-1:0]   mask_q, mask_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-1:0]      wb_data_q, wb_data_d;
    logic               wb_en_q, wb_en_d;
    logic               load_q, load_d;

    // Values computed from the live operands; only used when start is taken.
    logic [AW-1:0]      span;
    logic [AW-1:0]      first_addr;
    logic [AW-1:0]      wb_value;
    logic               wb_allow;
    logic [NREGS-1:0]   mask_next;
    logic               last_beat;

    // Number of set bits, widened to AW so it can be scaled directly.
    function automatic logic [AW-1:0] popcount(input logic [NREGS-1:0] v);
        logic [AW-1:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + AW'(v[i]);
        end
        return c;
    endfunction

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [RW-1:0] lowest_idx(input logic [NREGS-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = RW'(i);
            end
        end
        return r;
    endfunction

    // Operand-derived addresses: the block always occupies span bytes and
    // the lowest register always lands at the lowest address.
    always_comb begin
        span       = popcount(reg_list) * STEP;
        first_addr = base_addr;
        case ({p_bit, u_bit})
            2'b01:   first_addr = base_addr;                // IA
            2'b11:   first_addr = base_addr + STEP;         // IB
            2'b00:   first_addr = base_addr - span + STEP;  // DA
            default: first_addr = base_addr - span;         // DB
        endcase
        wb_value  = u_bit ? (base_addr + span) : (base_addr - span);
        // A load that includes the base keeps the loaded value instead.
        wb_allow  = w_bit & ~(l_bit & reg_list[base_reg]);
        mask_next = mask_q & (mask_q - MASK_ONE);
        last_beat = (mask_next == '0);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            load_q    <= load_d;
        end
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        wb_data_d = wb_data_q;
        wb_en_d   = wb_en_q;
        load_d    = load_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        reg_idx   = '0;
        reg_we    = 1'b0;
        wb_we     = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d    = reg_list;
                    addr_d    = first_addr;
                    wb_data_d = wb_value;
                    wb_en_d   = wb_allow;
                    load_d    = l_bit;
                    state_d   = (reg_list == '0) ? S_FIN : S_XFER;
                end
            end
            S_XFER: begin
                mem_req  = 1'b1;
                mem_we   = ~load_q;
                mem_addr = addr_q;
                reg_idx  = lowest_idx(mask_q);
                if (mem_ready) begin
                    reg_we = load_q;
                    mask_d = mask_next;
                    addr_d = addr_q + STEP;
                    if (last_beat) begin
                        state_d = wb_en_q ? S_WB : S_FIN;
                    end
                end
            end
            S_WB: begin
                wb_we   = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign wb_data   = wb_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_block_xfer_sequencer.sv
// Directed bench for block_xfer_sequencer. Cycle k is the cycle after
// clock edge k, where edge 0 is the edge that samples start.
module tb_block_xfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [3:0]  base_reg;
  logic        p_bit, u_bit, l_bit, w_bit;
  logic        mem_ready;
  logic        busy, mem_req, mem_we, reg_we, wb_we, done;
  logic [31:0] mem_addr, wb_data;
  logic [3:0]  reg_idx;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // observations from do_op
  logic [31:0] obs_addr[$];
  logic [3:0]  obs_idx[$];
  logic        obs_we[$];
  int          n_req, n_regwe, n_wbwe, wb_cycle, done_cycle;
  logic [31:0] wb_val;

  // expected beat addresses
  logic [31:0] exp_q[$];

  block_xfer_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .base_reg  (base_reg),
    .p_bit     (p_bit),
    .u_bit     (u_bit),
    .l_bit     (l_bit),
    .w_bit     (w_bit),
    .mem_ready (mem_ready),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .reg_idx   (reg_idx),
    .reg_we    (reg_we),
    .wb_we     (wb_we),
    .wb_data   (wb_data),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // Driver: called mid-cycle while the DUT is idle; starts one operation with
  // mem_ready high and records beats, writeback and done until done or 40 cycles.
  // Returns 1 time unit into the cycle after done. With poke set, a competing
  // start with different operands is driven in cycle 1.
  task automatic do_op(input logic [31:0] base, input logic [15:0] list,
                       input logic [3:0] breg, input logic p, input logic u,
                       input logic l, input logic w, input bit poke);
    int cyc;
    bit fin;
    obs_addr.delete(); obs_idx.delete(); obs_we.delete();
    n_req = 0; n_regwe = 0; n_wbwe = 0; wb_cycle = -1; done_cycle = -1; wb_val = '0;
    base_addr = base; reg_list = list; base_reg = breg;
    p_bit = p; u_bit = u; l_bit = l; w_bit = w; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    fin = 0;
    while (!fin && cyc <= 40) begin
      if (poke && cyc == 1) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; reg_list = 16'hFFFF;
        base_reg = 4'd0; u_bit = ~u; l_bit = ~l; w_bit = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (mem_req) n_req++;
      if (mem_req && mem_ready) begin
        obs_addr.push_back(mem_addr);
        obs_idx.push_back(reg_idx);
        obs_we.push_back(mem_we);
      end
      if (reg_we) n_regwe++;
      if (wb_we) begin n_wbwe++; wb_cycle = cyc; wb_val = wb_data; end
      if (done) begin done_cycle = cyc; fin = 1; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0; base_reg = '0;
    p_bit = 0; u_bit = 0; l_bit = 0; w_bit = 0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, mem_req, mem_we, reg_we, wb_we, done} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy/req/we/rwe/wbwe/done=%b required 000000",
               {busy, mem_req, mem_we, reg_we, wb_we, done});
    end
    n_cmp++;
    if (mem_addr !== 32'h0 || wb_data !== 32'h0 || reg_idx !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h wb_data=%h idx=%0d required 0/0/0",
               mem_addr, wb_data, reg_idx);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // STMIA base=0x1000 list=0x000F W=1
  task automatic test_stmia;
    logic [3:0] exp_idx[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    exp_q = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    do_op(32'h1000, 16'h000F, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs_addr.size() != 4) begin
      n_bad++; $display("FAIL stmia_beats: got %0d required 4", obs_addr.size());
    end
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== exp_q[i] || obs_idx[i] !== exp_idx[i] || obs_we[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL stmia_beat%0d: addr=%h idx=%0d we=%b required %h/%0d/1",
                 i, obs_addr[i], obs_idx[i], obs_we[i], exp_q[i], exp_idx[i]);
      end
    end
    n_cmp++;
    if (n_regwe != 0 || n_wbwe != 1 || wb_val !== 32'h1010 || wb_cycle != 5 || done_cycle != 6) begin
      n_bad++;
      $display("FAIL stmia_end: regwe=%0d wbwe=%0d wb=%h wbcyc=%0d donecyc=%0d required 0/1/1010/5/6",
               n_regwe, n_wbwe, wb_val, wb_cycle, done_cycle);
    end
  endtask

  // LDMDB base=0x2000 list=0x8011 W=1, with a start poked while busy
  task automatic test_ldmdb_busy_start;
    logic [3:0] exp_idx[3] = '{4'd0, 4'd4, 4'd15};
    exp_q = '{32'h1FF4, 32'h1FF8, 32'h1FFC};
    do_op(32'h2000, 16'h8011, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (obs_addr.size() != 3) begin
      n_bad++; $display("FAIL ldmdb_beats: got %0d required 3", obs_addr.size());
    end
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== exp_q[i] || obs_idx[i] !== exp_idx[i] || obs_we[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL ldmdb_beat%0d: addr=%h idx=%0d we=%b required %h/%0d/0",
                 i, obs_addr[i], obs_idx[i], obs_we[i], exp_q[i], exp_idx[i]);
      end
    end
    n_cmp++;
    if (n_regwe != 3 || n_wbwe != 1 || wb_val !== 32'h1FF4 || wb_cycle != 4 || done_cycle != 5) begin
      n_bad++;
      $display("FAIL ldmdb_end: regwe=%0d wbwe=%0d wb=%h wbcyc=%0d donecyc=%0d required 3/1/1FF4/4/5",
               n_regwe, n_wbwe, wb_val, wb_cycle, done_cycle);
    end
    #1;
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_start_ignored: busy=%b req=%b required 0/0", busy, mem_req);
    end
  endtask

  // LDMIB base=0x3000 list=0x0002, ready low for 3 cycles
  task automatic test_stall;
    base_addr = 32'h3000; reg_list = 16'h0002; base_reg = 4'd5;
    p_bit = 1; u_bit = 1; l_bit = 1; w_bit = 0; mem_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h3004 || reg_idx !== 4'd1 ||
          mem_we !== 1'b0 || reg_we !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold_c%0d: req=%b addr=%h idx=%0d we=%b rwe=%b required 1/3004/1/0/0",
                 c, mem_req, mem_addr, reg_idx, mem_we, reg_we);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (reg_we !== 1'b1 || mem_addr !== 32'h3004 || reg_idx !== 4'd1) begin
      n_bad++;
      $display("FAIL stall_accept: rwe=%b addr=%h idx=%0d required 1/3004/1", reg_we, mem_addr, reg_idx);
    end
    @(posedge clk); #1; #1;
    n_cmp++;
    if (done !== 1'b1 || mem_req !== 1'b0 || reg_we !== 1'b0 || wb_we !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_done: done=%b req=%b rwe=%b wbwe=%b required 1/0/0/0", done, mem_req, reg_we, wb_we);
    end
    @(posedge clk); #1;
  endtask

  // empty list with W=1
  task automatic test_empty;
    do_op(32'h1234, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (n_req != 0 || n_wbwe != 0 || done_cycle != 1) begin
      n_bad++;
      $display("FAIL empty_list: req=%0d wbwe=%0d donecyc=%0d required 0/0/1", n_req, n_wbwe, done_cycle);
    end
  endtask

  // base register in list: load suppresses writeback, store keeps it
  task automatic test_base_in_list;
    do_op(32'h5000, 16'h0006, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (n_wbwe != 0 || n_regwe != 2 || done_cycle != 3) begin
      n_bad++;
      $display("FAIL ldm_base_in_list: wbwe=%0d regwe=%0d donecyc=%0d required 0/2/3", n_wbwe, n_regwe, done_cycle);
    end
    do_op(32'h5000, 16'h0006, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (n_wbwe != 1 || wb_val !== 32'h5008 || wb_cycle != 3 || done_cycle != 4) begin
      n_bad++;
      $display("FAIL stm_base_in_list: wbwe=%0d wb=%h wbcyc=%0d donecyc=%0d required 1/5008/3/4",
               n_wbwe, wb_val, wb_cycle, done_cycle);
    end
    n_cmp++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 32'h5000 || obs_idx[1] !== 4'd2) begin
      n_bad++;
      $display("FAIL stm_base_beats: n=%0d required 2 beats at 5000 then idx 2", obs_addr.size());
    end
  endtask

  // STMDB base=0x4 list=0x0003: address wrap
  task automatic test_wrap;
    exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    do_op(32'h4, 16'h0003, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs_addr.size() != 2) begin
      n_bad++; $display("FAIL wrap_beats: got %0d required 2", obs_addr.size());
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] !== exp_q[i] || obs_idx[i] !== 4'(i)) begin
        n_bad++;
        $display("FAIL wrap_beat%0d: addr=%h idx=%0d required %h/%0d", i, obs_addr[i], obs_idx[i], exp_q[i], i);
      end
    end
    n_cmp++;
    if (n_wbwe != 1 || wb_val !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_wb: wbwe=%0d wb=%h required 1/FFFFFFFC", n_wbwe, wb_val);
    end
  endtask

  // reset after beat 1 of a 4-beat LDMIA, then a normal LDMDA
  task automatic test_reset_mid;
    int stray;
    base_addr = 32'h6000; reg_list = 16'h00F0; base_reg = 4'd1;
    p_bit = 0; u_bit = 1; l_bit = 1; w_bit = 1; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    n_cmp++;
    if (reg_we !== 1'b1 || mem_addr !== 32'h6000 || reg_idx !== 4'd4) begin
      n_bad++;
      $display("FAIL rmid_beat1: rwe=%b addr=%h idx=%0d required 1/6000/4", reg_we, mem_addr, reg_idx);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, mem_req, mem_we, reg_we, wb_we, done} !== 6'b0 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rmid_outputs: ctrl=%b addr=%h required 000000/0",
               {busy, mem_req, mem_we, reg_we, wb_we, done}, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mem_req || reg_we || wb_we || done) stray++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++; $display("FAIL rmid_quiet: active cycles=%0d required 0", stray);
    end
    // LDMDA base=0x7000 list=0x0005: n=2, A0=0x6FFC, wb=0x6FF8
    do_op(32'h7000, 16'h0005, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 32'h6FFC || obs_addr[1] !== 32'h7000 ||
        obs_idx[0] !== 4'd0 || obs_idx[1] !== 4'd2) begin
      n_bad++;
      $display("FAIL rmid_restart_beats: n=%0d required 6FFC/idx0 then 7000/idx2", obs_addr.size());
    end
    n_cmp++;
    if (n_wbwe != 1 || wb_val !== 32'h6FF8 || done_cycle != 4) begin
      n_bad++;
      $display("FAIL rmid_restart_end: wbwe=%0d wb=%h donecyc=%0d required 1/6FF8/4", n_wbwe, wb_val, done_cycle);
    end
  endtask

  // do_op returns in the idle cycle after done, so the next start is back to back
  task automatic test_back_to_back;
    do_op(32'h8000, 16'h0001, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(32'h9000, 16'h0003, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 32'h9004 || obs_addr[1] !== 32'h9008 ||
        n_wbwe != 0 || done_cycle != 3) begin
      n_bad++;
      $display("FAIL back_to_back: n=%0d wbwe=%0d donecyc=%0d required 2 beats 9004/9008, 0, 3",
               obs_addr.size(), n_wbwe, done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_stmia();
    test_ldmdb_busy_start();
    test_stall();
    test_empty();
    test_base_in_list();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
